// File: rtl/demux_dest_n.sv
// N-way destination demultiplexer: pops a show-ahead source FIFO through a one-entry
// holding register and steers each word to the destination named by its select field.
module demux_dest_n #(
    parameter int DATA_SIZE = 6,
    parameter int NUM_OUT   = 4,
    parameter int SEL_W     = 2,
    parameter int SEL_LSB   = 3,
    parameter int CNT_W     = 8
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic                     enable,
    input  logic                     fifo_empty,
    input  logic [DATA_SIZE-1:0]     data_in,
    output logic                     pop,
    input  logic [NUM_OUT-1:0]       almost_full,
    output logic [NUM_OUT-1:0]       push,
    output logic [DATA_SIZE-1:0]     data_out,
    output logic [NUM_OUT*CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     sel_err
);

    typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} state_t;

    localparam logic [SEL_W:0] NUM_OUT_CMP = (SEL_W + 1)'(NUM_OUT);

    state_t                 state_reg;
    logic [DATA_SIZE-1:0]   hold_data_reg;
    logic [NUM_OUT-1:0]     push_reg;
    logic [DATA_SIZE-1:0]   data_out_reg;
    logic [CNT_W-1:0]       drop_cnt_reg;
    logic                   sel_err_reg;

    logic                   hold_valid;
    logic [SEL_W-1:0]       sel;
    logic [NUM_OUT-1:0]     sel_onehot;
    logic                   bad;
    logic                   fire;

    assign hold_valid = (state_reg == HELD);
    assign sel        = hold_data_reg[SEL_LSB +: SEL_W];

    // Decoding to one-hot lets backpressure be checked for the selected target only.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_OUT; gi++) begin : g_dec
            assign sel_onehot[gi] = (sel == SEL_W'(gi));
        end
    endgenerate

    assign bad  = hold_valid && ({1'b0, sel} >= NUM_OUT_CMP);
    assign fire = hold_valid && !bad && ((almost_full & sel_onehot) == '0);
    assign pop  = reset_L && enable && !fifo_empty && (!hold_valid || fire || bad);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_reg     <= EMPTY;
            hold_data_reg <= '0;
            push_reg      <= '0;
            data_out_reg  <= '0;
            drop_cnt_reg  <= '0;
            sel_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (pop) begin
                        hold_data_reg <= data_in;
                        state_reg     <= HELD;
                    end
                end
                HELD: begin
                    // A pop in HELD always coincides with the held word leaving.
                    if (pop) begin
                        hold_data_reg <= data_in;
                    end else if (fire || bad) begin
                        state_reg <= EMPTY;
                    end
                end
                default: state_reg <= EMPTY;
            endcase

            push_reg     <= fire ? sel_onehot : '0;
            data_out_reg <= fire ? hold_data_reg : '0;

            if (bad) begin
                drop_cnt_reg <= drop_cnt_reg + 1'b1;
                sel_err_reg  <= 1'b1;
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_OUT; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk or negedge reset_L) begin
                if (!reset_L) begin
                    cnt_reg <= '0;
                end else if (fire && sel_onehot[gi]) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
            assign word_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
        end
    endgenerate

    assign push     = push_reg;
    assign data_out = data_out_reg;
    assign drop_cnt = drop_cnt_reg;
    assign sel_err  = sel_err_reg;

endmodule

// File: tb/tb_demux_dest_n.sv
// Scoreboard bench for demux_dest_n: a source FIFO model feeds the DUT and expected
// pushes are queued at enqueue time, then matched against observed pushes.
module tb_demux_dest_n;

    localparam int DW  = 6;
    localparam int NO  = 4;
    localparam int SW  = 3;
    localparam int SL  = 3;
    localparam int CW  = 8;

    typedef struct {
        int          dest;
        logic [DW-1:0] data;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset_L;
    logic               enable;
    logic               fifo_empty;
    logic [DW-1:0]      data_in;
    logic               pop;
    logic [NO-1:0]      almost_full;
    logic [NO-1:0]      push;
    logic [DW-1:0]      data_out;
    logic [NO*CW-1:0]   word_cnt;
    logic [CW-1:0]      drop_cnt;
    logic               sel_err;

    demux_dest_n #(
        .DATA_SIZE(DW), .NUM_OUT(NO), .SEL_W(SW), .SEL_LSB(SL), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset_L(reset_L), .enable(enable), .fifo_empty(fifo_empty),
        .data_in(data_in), .pop(pop), .almost_full(almost_full), .push(push),
        .data_out(data_out), .word_cnt(word_cnt), .drop_cnt(drop_cnt), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] src_q[$];
    exp_t          exp_q[$];
    int            push_cyc_q[$];
    logic [CW-1:0] m_cnt [NO];
    logic [CW-1:0] m_drop;
    logic          m_err;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic void refresh();
        fifo_empty = (src_q.size() == 0);
        data_in    = fifo_empty ? '0 : src_q[0];
    endfunction

    function automatic void model_clear();
        for (int d = 0; d < NO; d++) m_cnt[d] = '0;
        m_drop = '0;
        m_err  = 1'b0;
        exp_q.delete();
    endfunction

    task automatic enq(input logic [DW-1:0] w);
        logic [SW-1:0] s;
        exp_t e;
        s = w[SL +: SW];
        src_q.push_back(w);
        if (int'(s) < NO) begin
            e.dest = int'(s);
            e.data = w;
            exp_q.push_back(e);
            m_cnt[s] = m_cnt[s] + 1'b1;
        end else begin
            m_drop = m_drop + 1'b1;
            m_err  = 1'b1;
        end
        refresh();
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || src_q.size() != 0) && k < budget) begin
            tick(1);
            k++;
        end
        check("drain", exp_q.size(), 0);
        tick(3);
    endtask

    task automatic check_counters(input string tag);
        for (int d = 0; d < NO; d++)
            check($sformatf("%s_word_cnt%0d", tag, d), 32'(word_cnt[d*CW +: CW]), 32'(m_cnt[d]));
        check({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
        check({tag, "_sel_err"}, 32'(sel_err), 32'(m_err));
    endtask

    // Source FIFO model: pop is sampled mid-cycle and the head retired after the edge.
    initial begin
        logic pop_seen;
        forever begin
            @(negedge clk);
            pop_seen = pop;
            @(posedge clk);
            #1;
            if (pop_seen && src_q.size() > 0) begin
                void'(src_q.pop_front());
                refresh();
            end
        end
    end

    // Output monitor: every push must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_L === 1'b1) begin
                if (push != '0) begin
                    push_cyc_q.push_back(cyc);
                    $display("push cyc=%0d push=%b data=%b", cyc, push, data_out);
                    if (exp_q.size() == 0) begin
                        check("push_unexpected", 32'(push), 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        check("push_dest", 32'(push), 32'(1) << e.dest);
                        check("push_data", 32'(data_out), 32'(e.data));
                    end
                end else begin
                    check("idle_data_out", 32'(data_out), 32'h0);
                end
            end
        end
    end

    initial begin
        int k;
        reset_L     = 1'b0;
        enable      = 1'b1;
        almost_full = '0;
        fifo_empty  = 1'b0;
        data_in     = 6'b000101;
        model_clear();

        // Reset with a non-empty source must hold everything quiet.
        repeat (3) @(negedge clk);
        check("rst_pop", 32'(pop), 32'h0);
        check("rst_push", 32'(push), 32'h0);
        check("rst_data_out", 32'(data_out), 32'h0);
        check_counters("rst");
        @(posedge clk);
        #1;
        refresh();
        reset_L = 1'b1;
        tick(2);

        // Streaming: one word per cycle, first push two cycles after the head appears.
        push_cyc_q.delete();
        k = cyc;
        enq(6'b000101);
        enq(6'b001010);
        enq(6'b010011);
        enq(6'b011111);
        wait_drain(50);
        check("stream_npush", push_cyc_q.size(), 4);
        if (push_cyc_q.size() == 4) begin
            check("stream_first_cyc", push_cyc_q[0], k + 2);
            check("stream_last_cyc", push_cyc_q[3], k + 5);
        end
        check_counters("stream");

        // Backpressure on destination 2; the following sel=0 word ignores almost_full[1].
        push_cyc_q.delete();
        almost_full = 4'b0100;
        enq(6'b010001);
        enq(6'b000110);
        tick(6);
        @(negedge clk);
        check("bp_stall_pop", 32'(pop), 32'h0);
        check("bp_stall_npush", push_cyc_q.size(), 0);
        @(posedge clk);
        #1;
        almost_full = 4'b0010;
        k = cyc;
        wait_drain(50);
        check("bp_npush", push_cyc_q.size(), 2);
        if (push_cyc_q.size() == 2) begin
            check("bp_release_cyc", push_cyc_q[0], k + 1);
            check("bp_next_cyc", push_cyc_q[1], k + 2);
        end
        almost_full = '0;
        check_counters("bp");

        // Out-of-range select is dropped; the next valid word still routes.
        push_cyc_q.delete();
        enq(6'b100010);
        enq(6'b001001);
        wait_drain(50);
        check("oor_npush", push_cyc_q.size(), 1);
        check_counters("oor");

        // Enable drops while a word is held behind backpressure.
        push_cyc_q.delete();
        almost_full = 4'b0001;
        enq(6'b000011);
        enq(6'b000100);
        tick(3);
        enable = 1'b0;
        @(negedge clk);
        check("en_off_pop", 32'(pop), 32'h0);
        tick(3);
        check("en_off_npush", push_cyc_q.size(), 0);
        almost_full = '0;
        tick(4);
        check("en_off_fired", push_cyc_q.size(), 1);
        check("en_off_src_left", src_q.size(), 1);
        enable = 1'b1;
        wait_drain(50);
        check_counters("en");

        // Reset while HELD discards the word and clears every output at once.
        push_cyc_q.delete();
        almost_full = 4'b0001;
        enq(6'b000111);
        tick(3);
        reset_L = 1'b0;
        #1;
        model_clear();
        check("mid_rst_push", 32'(push), 32'h0);
        check("mid_rst_data_out", 32'(data_out), 32'h0);
        check("mid_rst_pop", 32'(pop), 32'h0);
        check_counters("mid_rst");
        tick(1);
        almost_full = '0;
        tick(2);
        reset_L = 1'b1;
        tick(5);
        check("mid_rst_no_push", push_cyc_q.size(), 0);

        // Counter wrap: 257 words to destination 1.
        push_cyc_q.delete();
        for (int i = 0; i < 257; i++) begin
            logic [2:0] lo;
            lo = i[2:0];
            enq({3'b001, lo});
        end
        wait_drain(1000);
        check("wrap_npush", push_cyc_q.size(), 257);
        check_counters("wrap");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d checks so far", n_pass, n_checks);
        $fatal(1, "timeout");
    end

endmodule
